// File: rtl/seq_feeder_pkg.sv
// rtl/seq_feeder_pkg.sv - shared sizing constants and FSM state encoding for the sequence feeder
package seq_feeder_pkg;

  localparam int FEED_N           = 8;
  localparam int FEED_BP_WIDTH    = 2;
  localparam int FEED_SEQ_MAX_LEN = 256;
  localparam int FEED_LEN_W       = 12;
  localparam int FEED_ADDR_W      = 12;
  localparam logic [FEED_BP_WIDTH-1:0] FEED_PAD_BASE = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_NEWSEQ,
    ST_S_PRE,
    ST_LOAD_S,
    ST_S_UPD,
    ST_T_PRE,
    ST_STREAM_T,
    ST_WAIT_BUSY,
    ST_FIN
  } feeder_state_t;

endpackage

// File: rtl/seq_rd_pipe.sv
// rtl/seq_rd_pipe.sv - one-ahead RAM read strobe/address and rd_data-to-S/T hold registers
module seq_rd_pipe #(
  parameter int BP_WIDTH = 2,
  parameter int LEN_W    = 12,
  parameter int ADDR_W   = 12,
  parameter logic [BP_WIDTH-1:0] PAD_BASE = '0
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                req,
  input  logic                req_ok,
  input  logic [ADDR_W-1:0]   req_base,
  input  logic [LEN_W-1:0]    req_off,
  input  logic                take_s,
  input  logic                take_t,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [BP_WIDTH-1:0] rd_data,
  output logic [BP_WIDTH-1:0] S,
  output logic [BP_WIDTH-1:0] T
);

  logic                pad_q;
  logic [BP_WIDTH-1:0] cur;
  logic [BP_WIDTH-1:0] s_hold;
  logic [BP_WIDTH-1:0] t_hold;

  // A read slot beyond the sequence end issues no strobe and is remembered as a pad for the next cycle
  always_comb begin
    rd_en   = req & req_ok;
    rd_addr = rd_en ? (req_base + ADDR_W'(req_off)) : '0;
    cur     = pad_q ? PAD_BASE : rd_data;
    S       = take_s ? cur : s_hold;
    T       = take_t ? cur : t_hold;
  end

  // Pad flag follows the read slot by one cycle; S and T keep their last qualified base
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      pad_q  <= 1'b0;
      s_hold <= '0;
      t_hold <= '0;
    end else begin
      pad_q  <= req & ~req_ok;
      s_hold <= S;
      t_hold <= T;
    end
  end

endmodule

// File: rtl/seq_feeder.sv
// rtl/seq_feeder.sv - systolic array load sequencer; FEEDER_STATS_EN adds cycle_cnt and tile_idx outputs
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int N           = FEED_N,
  parameter int BP_WIDTH    = FEED_BP_WIDTH,
  parameter int SEQ_MAX_LEN = FEED_SEQ_MAX_LEN,
  parameter int LEN_W       = FEED_LEN_W,
  parameter int ADDR_W      = FEED_ADDR_W,
  parameter logic [BP_WIDTH-1:0] PAD_BASE = FEED_PAD_BASE
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                start,
  input  logic [LEN_W-1:0]    s_len,
  input  logic [LEN_W-1:0]    t_len,
  input  logic [ADDR_W-1:0]   s_base,
  input  logic [ADDR_W-1:0]   t_base,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [BP_WIDTH-1:0] rd_data,
  output logic [BP_WIDTH-1:0] S,
  output logic [BP_WIDTH-1:0] T,
  output logic                s_update,
  output logic                ack,
  output logic                valid,
  output logic                new_seq,
  input  logic                busy,
  output logic                feeder_busy,
  output logic                done,
  output logic                err
`ifdef FEEDER_STATS_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [LEN_W-1:0]    tile_idx
`endif
);

  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] N_L   = LEN_W'(N);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(SEQ_MAX_LEN);

  feeder_state_t state, next;
  logic [LEN_W-1:0]  s_len_q, t_len_q, tiles_q, j_q, cnt_q, tile_off;
  logic [ADDR_W-1:0] s_base_q, t_base_q, req_base;
  logic [LEN_W-1:0]  req_off;
  logic              req, req_ok, take_s, take_t, bad_len;

  assign bad_len     = (s_len > MAX_L) || (t_len > MAX_L);
  assign tile_off    = j_q * N_L;
  assign feeder_busy = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state <= ST_IDLE;
    else          state <= next;
  end

  // Next state, handshake outputs and the read slot for the base shown one cycle later
  always_comb begin
    next     = state;
    req      = 1'b0;
    req_ok   = 1'b0;
    req_base = s_base_q;
    req_off  = '0;
    take_s   = 1'b0;
    take_t   = 1'b0;
    new_seq  = 1'b0;
    ack      = 1'b0;
    s_update = 1'b0;
    valid    = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start && !bad_len) next = ST_NEWSEQ;
      ST_NEWSEQ: begin
        new_seq = 1'b1;
        next    = (s_len_q == '0) ? ST_FIN : ST_S_PRE;
      end
      ST_S_PRE: begin
        ack     = 1'b1;
        req     = 1'b1;
        req_off = tile_off + N_L - ONE;
        req_ok  = req_off < s_len_q;
        next    = ST_LOAD_S;
      end
      ST_LOAD_S: begin
        ack    = 1'b1;
        take_s = 1'b1;
        if (cnt_q != '0) begin
          req     = 1'b1;
          req_off = tile_off + cnt_q - ONE;
          req_ok  = req_off < s_len_q;
        end else begin
          next = ST_S_UPD;
        end
      end
      ST_S_UPD: begin
        s_update = 1'b1;
        next     = ST_T_PRE;
      end
      ST_T_PRE: begin
        ack      = 1'b1;
        req_base = t_base_q;
        req      = (t_len_q != '0);
        req_ok   = 1'b1;
        next     = (t_len_q == '0) ? ST_WAIT_BUSY : ST_STREAM_T;
      end
      ST_STREAM_T: begin
        ack      = 1'b1;
        valid    = 1'b1;
        take_t   = 1'b1;
        req_base = t_base_q;
        if (cnt_q + ONE < t_len_q) begin
          req     = 1'b1;
          req_ok  = 1'b1;
          req_off = cnt_q + ONE;
        end else begin
          next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        ack = 1'b1;
        if (!busy) next = (j_q + ONE < tiles_q) ? ST_S_PRE : ST_FIN;
      end
      ST_FIN: begin
        done = 1'b1;
        next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  // Request latch, tile/base counters and the length-reject pulse
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      s_len_q  <= '0;
      t_len_q  <= '0;
      s_base_q <= '0;
      t_base_q <= '0;
      tiles_q  <= '0;
      j_q      <= '0;
      cnt_q    <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) && start && bad_len;
      case (state)
        ST_IDLE: if (start && !bad_len) begin
          s_len_q  <= s_len;
          t_len_q  <= t_len;
          s_base_q <= s_base;
          t_base_q <= t_base;
          tiles_q  <= (s_len + N_L - ONE) / N_L;
        end
        ST_NEWSEQ:    j_q <= '0;
        ST_S_PRE:     cnt_q <= N_L - ONE;
        ST_LOAD_S:    if (cnt_q != '0) cnt_q <= cnt_q - ONE;
        ST_T_PRE:     cnt_q <= '0;
        ST_STREAM_T:  cnt_q <= cnt_q + ONE;
        ST_WAIT_BUSY: if (!busy && (j_q + ONE < tiles_q)) j_q <= j_q + ONE;
        default: ;
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  // Pair cycle counter: clears on new_seq, counts while busy, holds from done until the next pair
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i)                cycle_cnt <= '0;
    else if (state == ST_NEWSEQ) cycle_cnt <= '0;
    else if (state != ST_IDLE)   cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign tile_idx = j_q;
`endif

  seq_rd_pipe #(
    .BP_WIDTH (BP_WIDTH),
    .LEN_W    (LEN_W),
    .ADDR_W   (ADDR_W),
    .PAD_BASE (PAD_BASE)
  ) u_rd_pipe (
    .clk      (clk),
    .reset_i  (reset_i),
    .req      (req),
    .req_ok   (req_ok),
    .req_base (req_base),
    .req_off  (req_off),
    .take_s   (take_s),
    .take_t   (take_t),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .S        (S),
    .T        (T)
  );

endmodule

// File: doc/seq_feeder.md
Name: seq_feeder

Overview:
- Host-side transmitter for the systolic alignment array.
- Fetches 2-bit bases of a query (S) and a target (T) from a base-addressed sequence RAM.
- Drives the array's load protocol: new_seq, serial S tile load, s_update, T stream with valid, then waits on array busy.
- Splits S into ceil(s_len/N) tiles. Replaces the bench-side sequencing loop in system-level runs.

Parameters:
- N, 8, number of PEs in the array (S tile length)
- BP_WIDTH, 2, bits per base
- SEQ_MAX_LEN, 256, longest legal S or T
- LEN_W, 12, width of length fields
- ADDR_W, 12, base-address width of the sequence RAM
- PAD_BASE, 2'b00, base value driven for S positions beyond s_len in the last tile

Ports:
- clk  in  1  clock
- reset_i  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored unless in IDLE
- s_len  in  LEN_W  query length in bases, sampled on start
- t_len  in  LEN_W  target length in bases, sampled on start
- s_base  in  ADDR_W  RAM address of S base 0, sampled on start
- t_base  in  ADDR_W  RAM address of T base 0, sampled on start
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM base address
- rd_data  in  BP_WIDTH  RAM data; valid the cycle after rd_en
- S  out  BP_WIDTH  serial query base to the array
- T  out  BP_WIDTH  streamed target base
- s_update  out  1  one-cycle tile commit
- ack  out  1  array-enable handshake
- valid  out  1  T qualifier
- new_seq  out  1  one-cycle new-pair pulse
- busy  in  1  array still computing
- feeder_busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle length-reject pulse

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; counters cleared. Applies from any state, including mid-stream.
- States: IDLE, NEWSEQ, S_PRE, LOAD_S, S_UPD, T_PRE, STREAM_T, WAIT_BUSY, FIN.
- IDLE: on start, s_len>SEQ_MAX_LEN or t_len>SEQ_MAX_LEN -> err=1 for 1 cycle, stay in IDLE. Otherwise latch the inputs and go to NEWSEQ.
- NEWSEQ: new_seq=1 for one cycle; ack rises the next cycle and stays 1 except during S_UPD.
  - s_len==0 -> FIN.
  - else tile j=0 -> S_PRE.
- S_PRE (1 cycle): issue read for tile index i=N-1 (address s_base+j*N+i).
- LOAD_S (N cycles): S carries bases in tile order i=N-1 down to 0, one per cycle. The next read is issued one cycle ahead of each base.
  - Positions with j*N+i >= s_len: drive PAD_BASE, rd_en=0.
- S_UPD (1 cycle): s_update=1, ack=0.
- T_PRE (1 cycle): ack=1; issue read at t_base.
  - t_len==0 -> WAIT_BUSY (no valid cycles).
- STREAM_T (t_len cycles): valid=1; T = base t_base+k for k=0..t_len-1, ascending. Reads are pipelined one cycle ahead.
- WAIT_BUSY: busy is sampled from the first cycle after the last valid. When busy==0:
  - if j+1 < ceil(s_len/N): j++ -> S_PRE
  - else -> FIN
- FIN: done=1 for one cycle, ack=0 -> IDLE.
- S, T hold their last value when not qualified. The array must ignore them then.
- Tile count uses integer ceil. Length counters are LEN_W wide; no wrap is possible given SEQ_MAX_LEN < 2^LEN_W.
- A start asserted while feeder_busy=1 is dropped silently.
- Pair latency (s_len>0, busy drops immediately) = 2 + tiles*(N+3+t_len+1) + 1 cycles from start to done.

Optional Feature:
- Macro FEEDER_STATS_EN.
- Defined: adds output cycle_cnt (32 bits). It clears on new_seq, increments every cycle while feeder_busy=1, and freezes at done until the next new_seq. Adds output tile_idx (LEN_W bits) equal to the current j.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package: BP_WIDTH, N, SEQ_MAX_LEN, LEN_W and the state encoding, shared with the array and benches.
- One sub-module: seq_rd_pipe. It holds the one-ahead RAM address generator and the rd_data-to-S/T register, including the PAD_BASE substitution.

Test Plan:
- N=4, s_len=4, t_len=3: new_seq at cycle 1; S sequence = bases 3,2,1,0; s_update 1 cycle with ack=0; valid for exactly 3 cycles; busy low -> done; single tile.
- s_len=10, N=4: 3 tiles; tile 2 S = PAD,PAD,base9,base8; s_update seen 3 times; done once.
- t_len=0, s_len=4: s_update pulses; valid never asserts; done after busy low.
- s_len=300: err pulse only; new_seq, rd_en and feeder_busy stay 0.
- Hold busy=1 for 5 cycles after the last valid: FSM stays in WAIT_BUSY 5 cycles and proceeds the cycle busy=0.
- Drop reset_i mid STREAM_T: valid, ack, feeder_busy go 0 immediately. A subsequent start runs a clean pair from new_seq.
